// File: rtl/seg7_scan_display.sv
// ---------------------------------------------------------------------------
// seg7_scan_display
//
// Four-digit multiplexed 7-segment scan driver for the packed BCD countdown
// word of the traffic-light controller (data[15:8] = NS pair, data[7:0] = WE
// pair). One digit is enabled at a time for DIV = CLK_HZ/SCAN_HZ clocks. The
// input word is latched once per frame so a frame never mixes old and new
// digits.
//
// Parameters:
//   CLK_HZ   input clock frequency in Hz
//   SCAN_HZ  per-digit dwell rate in Hz (CLK_HZ/SCAN_HZ must be >= 2)
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous, active-high reset
//   data  in   [15:12] NS tens, [11:8] NS units, [7:4] WE tens, [3:0] WE units
//   seg   out  segments {g,f,e,d,c,b,a}, active-low, registered
//   dp    out  decimal point, active-low, lit only on digit 2, registered
//   an    out  digit enables, active-low, an[0] = rightmost digit, registered
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, a zero in a tens position (digit 3
//                          or digit 1) is shown dark while its anode stays on.
// ---------------------------------------------------------------------------
module seg7_scan_display #(
    parameter int CLK_HZ  = 50000000,
    parameter int SCAN_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Nibble to active-low segment pattern; non-BCD codes show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt_r;
    logic [1:0]    idx_r;
    logic [15:0]   shadow_r;
    logic [6:0]    seg_r;
    logic          dp_r;
    logic [3:0]    an_r;

    logic          tick_s;
    logic [1:0]    idx_next_s;
    logic [3:0]    nib_s;
    logic          blank_s;
    logic [6:0]    seg_next_s;
    logic          dp_next_s;
    logic [3:0]    an_next_s;

    // Next-digit selection and decode for the value shown after the coming tick.
    always_comb begin
        tick_s     = (cnt_r == CNT_LAST);
        idx_next_s = idx_r + 2'd1;

        // Digit 0 opens a new frame: it reads data directly because the
        // shadow is being loaded with that same word on this very edge.
        case (idx_next_s)
            2'd0:    nib_s = data[3:0];
            2'd1:    nib_s = shadow_r[7:4];
            2'd2:    nib_s = shadow_r[11:8];
            2'd3:    nib_s = shadow_r[15:12];
            default: nib_s = data[3:0];
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        // Odd digit positions are the tens digits of each pair.
        if (idx_next_s[0] == 1'b1 && nib_s == 4'd0) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
`else
        blank_s = 1'b0;
`endif

        if (blank_s) begin
            seg_next_s = SEG_BLANK;
        end else begin
            seg_next_s = bcd_to_seg(nib_s);
        end

        if (idx_next_s == 2'd2) begin
            dp_next_s = 1'b0;
        end else begin
            dp_next_s = 1'b1;
        end

        an_next_s = ~(4'b0001 << idx_next_s);
    end

    // Prescaler, digit index, frame shadow and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= '0;
            idx_r    <= 2'd3;
            shadow_r <= 16'h0000;
            seg_r    <= SEG_BLANK;
            dp_r     <= 1'b1;
            an_r     <= 4'b1111;
        end else begin
            if (tick_s) begin
                cnt_r <= '0;
                idx_r <= idx_next_s;
                seg_r <= seg_next_s;
                dp_r  <= dp_next_s;
                an_r  <= an_next_s;
                if (idx_next_s == 2'd0) begin
                    shadow_r <= data;
                end
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign seg = seg_r;
    assign dp  = dp_r;
    assign an  = an_r;

endmodule

// File: tb/tb_seg7_scan_display.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_display
//
// Bench for seg7_scan_display at CLK_HZ=8, SCAN_HZ=2 (DIV=4), plus a second
// instance at DIV=2 for the minimum-divider case. Every clock the stimulus
// pushes the expected {an, seg, dp} for the state after the next edge; a
// negedge monitor pops and compares. Vectors live in a table of frames.
// ---------------------------------------------------------------------------
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [6:0]  seg,  seg2;
    logic        dp,   dp2;
    logic [3:0]  an,   an2;

    int checks = 0;
    int errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZT = 7'b1111111;
`else
    localparam logic [6:0] ZT = 7'b1000000;
`endif

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        string      tag;
    } exp_t;

    typedef struct {
        logic [15:0]      data;
        logic [3:0][6:0]  segs;
        string            name;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    seg7_scan_display #(.CLK_HZ(8), .SCAN_HZ(2)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .seg  (seg),
        .dp   (dp),
        .an   (an)
    );

    seg7_scan_display #(.CLK_HZ(4), .SCAN_HZ(2)) u_dut2 (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .seg  (seg2),
        .dp   (dp2),
        .an   (an2)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: compare the DUT against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
                errors++;
                $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                         e.tag, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    end

    function automatic exp_t blank(input string t);
        exp_t e;
        e.an  = 4'b1111;
        e.seg = 7'b1111111;
        e.dp  = 1'b1;
        e.tag = t;
        return e;
    endfunction

    function automatic exp_t lit(input int d, input logic [6:0] s, input string t);
        exp_t e;
        e.an  = ~(4'b0001 << d);
        e.seg = s;
        e.dp  = (d == 2) ? 1'b0 : 1'b1;
        e.tag = $sformatf("%s_d%0d", t, d);
        return e;
    endfunction

    function automatic vec_t mkvec(input logic [15:0] d, input logic [6:0] s3,
                                   input logic [6:0] s2, input logic [6:0] s1,
                                   input logic [6:0] s0, input string n);
        vec_t v;
        v.data = d;
        v.segs = {s3, s2, s1, s0};
        v.name = n;
        return v;
    endfunction

    task automatic step(input exp_t e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One frame starting from the frame-start tick (cnt=DIV-1, idx=3).
    task automatic run_frame(input vec_t v);
        data = v.data;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                step(lit(d, v.segs[d], v.name));
            end
        end
    endtask

    task automatic reset_seq(input int n, input string t);
        rst = 1'b1;
        for (int i = 0; i < n; i++) step(blank({t, "_held"}));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(blank({t, "_dark"}));
    endtask

    task automatic check_div2(input exp_t e);
        checks++;
        if (an2 !== e.an || seg2 !== e.seg || dp2 !== e.dp) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     e.tag, an2, seg2, dp2, e.an, e.seg, e.dp);
        end
    endtask

    initial begin
        vec_t v1919, v0808, v4321;

        vecs[0] = mkvec(16'h2010, 7'b0100100, 7'b1000000, 7'b1111001, 7'b1000000, "static_2010");
        vecs[1] = mkvec(16'h00A0, ZT,         7'b1000000, 7'b0111111, 7'b1000000, "invalid_00A0");
        vecs[2] = mkvec(16'h0509, ZT,         7'b0010010, ZT,         7'b0010000, "lzero_0509");
        vecs[3] = mkvec(16'h8765, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010, "digits_8765");
        vecs[4] = mkvec(16'h4321, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, "digits_4321");
        vecs[5] = mkvec(16'hFEDC, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, "dash_FEDC");
        v1919   = mkvec(16'h1919, 7'b1111001, 7'b0010000, 7'b1111001, 7'b0010000, "tear_1919");
        v0808   = mkvec(16'h0808, ZT,         7'b0000000, ZT,         7'b0000000, "next_0808");
        v4321   = vecs[4];

        rst  = 1'b1;
        data = 16'h0000;

        // Reset hold for three cycles, then four dark cycles (reset state
        // plus three prescaler counts) before digit 0 lights.
        reset_seq(3, "reset");

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i]);
        end

        // No tearing: change data while digit 1 is active.
        data = v1919.data;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (d == 1 && c == 1) data = v0808.data;
                step(lit(d, v1919.segs[d], v1919.name));
            end
        end
        run_frame(v0808);

        // Mid-frame reset while digit 2 is active.
        data = v4321.data;
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < ((d == 2) ? 2 : 4); c++) begin
                step(lit(d, v4321.segs[d], "prereset"));
            end
        end
        reset_seq(1, "midreset");
        run_frame(v4321);

        // DIV=2 instance: dark for one edge, then each digit held two clocks.
        data = vecs[3].data;
        rst  = 1'b1;
        step(blank("div2_rst"));
        check_div2(blank("div2_rst"));
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 3) step(blank("div2_main_dark"));
            else        step(lit((k - 4) / 4, vecs[3].segs[(k - 4) / 4], "div2_main"));
            if (k == 1) check_div2(blank("div2_dark"));
            else        check_div2(lit(((k - 2) / 2) % 4, vecs[3].segs[((k - 2) / 2) % 4], "div2"));
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Four-digit multiplexed 7-segment scan driver that consumes the packed BCD countdown word produced by the traffic-light controller. data[15:8] holds the NS pair and data[7:0] holds the WE pair. The block time-multiplexes the four digits onto one shared active-low segment bus at a fixed refresh rate. It latches the input once per scan frame so that no frame ever shows a mix of old and new digits.

## Interface
- CLK_HZ, 50000000: input clock frequency in Hz.
- SCAN_HZ, 1000: per-digit dwell rate in Hz. DIV = CLK_HZ/SCAN_HZ must be ≥ 2.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- data  in  16  packed BCD: [15:12] NS tens, [11:8] NS units, [7:4] WE tens, [3:0] WE units.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  4  digit enables, active-low. an[0] is the rightmost digit (data[3:0]) and an[3] is data[15:12].

## Operation
- Prescaler cnt counts 0..DIV-1 and wraps. Width is $clog2(DIV). tick is asserted when cnt == DIV-1.
- Digit index idx is 2 bits. It advances idx+1 mod 4 on tick and resets to 3.
- Frame load:
  - On the tick that moves idx to 0, shadow[15:0] <= data.
  - Digit 0 shown on that tick decodes from data[3:0] directly, which is the same value being loaded.
  - Digits 1-3 decode from shadow.
- Decode, nibble to seg:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any nibble 10-15 shows '-' = 0111111.
- dp = 0 only while idx == 2, giving a separator between the NS and WE pairs. Otherwise dp = 1.
- an = ~(1<<idx). Exactly one digit is enabled after the first tick.
- seg, dp and an are registered and update together on the tick edge.

## Timing
- Reset values: cnt=0, idx=3, shadow=0, an=4'b1111, seg=7'b1111111, dp=1.
- After reset, all digits stay dark for cycles 0..DIV-1. The first tick at cycle DIV-1 drives digit 0 from the next edge onward.
- Each digit is held for exactly DIV clocks. A full frame is 4*DIV clocks.
- Latency: data is sampled at the frame-start tick edge and appears on digit 0 one clock later. The other digits appear at their scheduled slots.
- A data change mid-frame is ignored until the next frame-start tick. There is no tearing within a frame.
- rst asserted mid-frame: outputs are blank on the next edge and the scan restarts exactly as after power-on reset. rst takes priority over a coincident tick.
- DIV=2 is the minimum. tick then fires every other cycle, and behaviour is otherwise identical.

## Configuration
- LEADING_ZERO_BLANK_EN, if defined:
  - For digit 3 (NS tens) and digit 1 (WE tens), a tens nibble of 0 forces seg=1111111 while that digit is active.
  - an is still asserted and dp is unaffected.
  - Units digits always display.
- If not defined, zero tens digits display '0' (1000000).

## Test plan
All scenarios use CLK_HZ=8, SCAN_HZ=2, so DIV=4.
- Reset hold: rst=1 for 3 cycles, then release → an=1111, seg=1111111, dp=1 for 4 cycles. an=1110 from cycle 4.
- Static value data=16'h2010, one full frame → digit0 seg=1000000 dp=1, digit1 1111001, digit2 1000000 dp=0, digit3 0100100. Each digit is held 4 clocks with the correct an.
- No tearing: data=16'h1919, then change to 16'h0808 while digit 1 is active → digits 2-3 still show 9/1. All digits show 8/0 from the next frame.
- Invalid BCD: data=16'h00A0 → digit1 seg=0111111. Other digits are decoded normally.
- Leading zero, data=16'h0509 → with LEADING_ZERO_BLANK_EN, digits 3 and 1 show seg=1111111 with an active, and digits 2/0 show 0010010 / 0010000. Without the macro, digits 3 and 1 show 1000000.
- Mid-frame reset: assert rst for 1 cycle while idx=2 → next cycle an=1111, seg=1111111, dp=1. Digit 0 reappears 4 clocks after release.
